trace_decoder: RTL and testbench
================================

TRACE_DECODER -- requirements
Module: trace_decoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 23, RAM word-address width.
REQ-002 SHALL have parameter TIME_W, default 32, absolute-timestamp width.
REQ-003 SHALL have port mclk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port pkt_valid  input  1  trace packet present.
REQ-006 SHALL have port pkt_ready  output  1  packet consumed when pkt_valid && pkt_ready.
REQ-007 SHALL have port pkt_type  input  2  00 address, 01 read word, 10 write word, 11 timestamp.
REQ-008 SHALL have port pkt_payload  input  23  address, {ts5[4:0], ublb[1:0], data[15:0]}, or timestamp count.
REQ-009 SHALL have port ev_valid  output  1  decoded bus event held.
REQ-010 SHALL have port ev_ready  input  1  event consumed when ev_valid && ev_ready.
REQ-011 SHALL have port ev_write  output  1  1 write, 0 read.
REQ-012 SHALL have port ev_addr  output  ADDR_W  word address of event.
REQ-013 SHALL have port ev_ublb  output  2  byte lanes, packet bits [17:16].
REQ-014 SHALL have port ev_data  output  16  data word.
REQ-015 SHALL have port ev_time  output  TIME_W  absolute cycle time of event.
REQ-016 SHALL have port err_no_addr  output  1  sticky: data packet arrived with no burst address.

Function
REQ-017 SHALL hold state: cur_addr (ADDR_W), addr_valid (1), time_acc (TIME_W).
REQ-018 pkt_ready SHALL equal !ev_valid || ev_ready (combinational, one output stage, full throughput).
REQ-019 Address packet SHALL load cur_addr from payload, set addr_valid, leave time_acc unchanged, emit nothing.
REQ-020 Timestamp packet SHALL add zero-extended 23-bit payload to time_acc, emit nothing, keep addr state.
REQ-021 Read/write packet with addr_valid SHALL add ts5 to time_acc, emit event next cycle with ev_time = new time_acc, ev_addr = cur_addr, then increment cur_addr.
REQ-022 Event latency SHALL be exactly 1 cycle from packet handshake to ev_valid high.
REQ-023 ev_* SHALL remain stable while ev_valid && !ev_ready.
REQ-024 cur_addr increment SHALL wrap modulo 2^ADDR_W; time_acc SHALL wrap modulo 2^TIME_W.
REQ-025 Data packet without addr_valid SHALL be consumed, dropped (no event), still add ts5 to time_acc, set err_no_addr.
REQ-026 Simultaneous ev_ready handshake and new data packet SHALL replace the event in the same cycle, no bubble.
REQ-027 ts5 = 0 SHALL be legal; consecutive events may share ev_time.

Reset
REQ-028 reset_n low at rising mclk SHALL clear ev_valid, addr_valid, err_no_addr, cur_addr, time_acc, ev_* to 0.
REQ-029 Reset mid-burst SHALL discard any held event; first post-reset data packet without address SHALL set err_no_addr.

Configuration
REQ-030 Macro TRACE_DECODER_STATS_EN defined SHALL add outputs stat_reads, stat_writes, stat_ts (16 bits each, saturating at 16'hFFFF, counting consumed packets, cleared by reset).
REQ-031 Macro undefined SHALL omit those ports and counters entirely; other behaviour identical.

Structure
REQ-032 Package trace_pkg SHALL hold packet-type constants (PKT_ADDR, PKT_READ, PKT_WRITE, PKT_TIME), payload field offsets, TS5_W = 5.
REQ-033 One sub-module trace_evt_reg SHALL implement the valid/ready output register; decode and accumulators stay in trace_decoder.

Verification
REQ-034 Reset, address 0x000100, read ts5=3 data 0xBEEF, read ts5=1 data 0x1234 -> events (R, 0x000100, t=3, 0xBEEF), (R, 0x000101, t=4, 0x1234).
REQ-035 Timestamp 0x400000 then write ts5=31 ublb=2'b01 data 0x0078 after address 0x4394F0 -> event (W, 0x4394F0, t=0x40001F, ublb 01).
REQ-036 ev_ready low 5 cycles with packets pending -> pkt_ready low, ev_* stable, no loss; release -> remaining events in order one per cycle.
REQ-037 Address 0x7FFFFF then two reads -> ev_addr 0x7FFFFF then 0x000000.
REQ-038 Read packet before any address -> no ev_valid, err_no_addr=1, time_acc advanced by ts5; reset_n low -> err_no_addr=0.
REQ-039 With TRACE_DECODER_STATS_EN, 70000 read packets -> stat_reads = 16'hFFFF.

Source files
------------

// File: rtl/trace_pkg.sv
// Trace packet definitions shared by the trace decoder slice.
// Holds packet-type codes and field positions inside the 23-bit data payload
// {ts5[4:0], ublb[1:0], data[15:0]}.
package trace_pkg;

  localparam int unsigned PAYLOAD_W = 23;
  localparam int unsigned DATA_LSB  = 0;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned UBLB_LSB  = 16;
  localparam int unsigned UBLB_W    = 2;
  localparam int unsigned TS5_LSB   = 18;
  localparam int unsigned TS5_W     = 5;
  localparam int unsigned STAT_W    = 16;

  localparam logic [1:0] PKT_ADDR  = 2'b00;
  localparam logic [1:0] PKT_READ  = 2'b01;
  localparam logic [1:0] PKT_WRITE = 2'b10;
  localparam logic [1:0] PKT_TIME  = 2'b11;

endpackage

// File: rtl/trace_evt_reg.sv
// Single-entry valid/ready output register for decoded bus events.
// Ports:
//   mclk, reset_n          clock, synchronous active-low reset
//   load                   capture in_* as a new event (only asserted when in_ready)
//   in_write..in_time      event fields to capture
//   in_ready               register can accept: empty, or being drained this cycle
//   ev_valid, ev_ready     downstream handshake
//   ev_write..ev_time      held event fields, stable while ev_valid && !ev_ready
module trace_evt_reg
  import trace_pkg::*;
#(
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned TIME_W = 32
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              in_write,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [1:0]        in_ublb,
  input  logic [15:0]       in_data,
  input  logic [TIME_W-1:0] in_time,
  output logic              in_ready,
  input  logic              ev_ready,
  output logic              ev_valid,
  output logic              ev_write,
  output logic [ADDR_W-1:0] ev_addr,
  output logic [1:0]        ev_ublb,
  output logic [15:0]       ev_data,
  output logic [TIME_W-1:0] ev_time
);

  // Draining and refilling in the same cycle keeps full throughput.
  assign in_ready = !ev_valid || ev_ready;

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      ev_valid <= 1'b0;
      ev_write <= 1'b0;
      ev_addr  <= '0;
      ev_ublb  <= '0;
      ev_data  <= '0;
      ev_time  <= '0;
    end else if (load) begin
      ev_valid <= 1'b1;
      ev_write <= in_write;
      ev_addr  <= in_addr;
      ev_ublb  <= in_ublb;
      ev_data  <= in_data;
      ev_time  <= in_time;
    end else if (ev_ready) begin
      ev_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/trace_decoder.sv
// Trace packet decoder: turns a stream of address / read / write / timestamp
// packets into bus events carrying absolute time and auto-incrementing address.
// Ports:
//   mclk, reset_n                   clock, synchronous active-low reset
//   pkt_valid, pkt_ready            input packet handshake
//   pkt_type, pkt_payload           packet type code and 23-bit payload
//   ev_valid, ev_ready              output event handshake
//   ev_write, ev_addr, ev_ublb,
//   ev_data, ev_time                decoded event fields
//   stat_reads, stat_writes,
//   stat_ts                         saturating packet counters (TRACE_DECODER_STATS_EN only)
//   err_no_addr                     sticky: data packet seen with no burst address
// Config macro: TRACE_DECODER_STATS_EN adds the statistics counters and ports.
module trace_decoder
  import trace_pkg::*;
#(
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned TIME_W = 32
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic [1:0]        pkt_type,
  input  logic [22:0]       pkt_payload,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic              ev_write,
  output logic [ADDR_W-1:0] ev_addr,
  output logic [1:0]        ev_ublb,
  output logic [15:0]       ev_data,
  output logic [TIME_W-1:0] ev_time,
`ifdef TRACE_DECODER_STATS_EN
  output logic [15:0]       stat_reads,
  output logic [15:0]       stat_writes,
  output logic [15:0]       stat_ts,
`endif
  output logic              err_no_addr
);

  logic [ADDR_W-1:0] cur_addr;
  logic              addr_valid;
  logic [TIME_W-1:0] time_acc;
  logic [TIME_W-1:0] time_next;
  logic              hs;
  logic              is_data;
  logic              emit;
  logic [TS5_W-1:0]  ts5;

  assign hs      = pkt_valid && pkt_ready;
  assign is_data = (pkt_type == PKT_READ) || (pkt_type == PKT_WRITE);
  assign ts5     = pkt_payload[TS5_LSB +: TS5_W];
  assign emit    = hs && is_data && addr_valid;

  // Data packets advance time even when dropped for lack of an address.
  always_comb begin
    time_next = time_acc;
    if (hs) begin
      unique case (pkt_type)
        PKT_TIME:            time_next = time_acc + TIME_W'(pkt_payload);
        PKT_READ, PKT_WRITE: time_next = time_acc + TIME_W'(ts5);
        default:             time_next = time_acc;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      cur_addr    <= '0;
      addr_valid  <= 1'b0;
      time_acc    <= '0;
      err_no_addr <= 1'b0;
    end else begin
      time_acc <= time_next;
      if (hs && (pkt_type == PKT_ADDR)) begin
        cur_addr   <= ADDR_W'(pkt_payload);
        addr_valid <= 1'b1;
      end else if (emit) begin
        cur_addr <= cur_addr + ADDR_W'(1);
      end
      if (hs && is_data && !addr_valid) begin
        err_no_addr <= 1'b1;
      end
    end
  end

  trace_evt_reg #(
    .ADDR_W (ADDR_W),
    .TIME_W (TIME_W)
  ) u_evt_reg (
    .mclk     (mclk),
    .reset_n  (reset_n),
    .load     (emit),
    .in_write (pkt_type == PKT_WRITE),
    .in_addr  (cur_addr),
    .in_ublb  (pkt_payload[UBLB_LSB +: UBLB_W]),
    .in_data  (pkt_payload[DATA_LSB +: DATA_W]),
    .in_time  (time_next),
    .in_ready (pkt_ready),
    .ev_ready (ev_ready),
    .ev_valid (ev_valid),
    .ev_write (ev_write),
    .ev_addr  (ev_addr),
    .ev_ublb  (ev_ublb),
    .ev_data  (ev_data),
    .ev_time  (ev_time)
  );

`ifdef TRACE_DECODER_STATS_EN
  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_ts     <= '0;
    end else if (hs) begin
      if ((pkt_type == PKT_READ) && (stat_reads != 16'hFFFF)) begin
        stat_reads <= stat_reads + 16'd1;
      end
      if ((pkt_type == PKT_WRITE) && (stat_writes != 16'hFFFF)) begin
        stat_writes <= stat_writes + 16'd1;
      end
      if ((pkt_type == PKT_TIME) && (stat_ts != 16'hFFFF)) begin
        stat_ts <= stat_ts + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_trace_decoder.sv
// Self-checking bench for trace_decoder: directed scenarios plus randomized
// traffic, compared every cycle against a packet-level reference model.
module tb_trace_decoder;
  import trace_pkg::*;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned TIME_W = 32;

  logic              mclk;
  logic              reset_n;
  logic              pkt_valid;
  logic              pkt_ready;
  logic [1:0]        pkt_type;
  logic [22:0]       pkt_payload;
  logic              ev_valid;
  logic              ev_ready;
  logic              ev_write;
  logic [ADDR_W-1:0] ev_addr;
  logic [1:0]        ev_ublb;
  logic [15:0]       ev_data;
  logic [TIME_W-1:0] ev_time;
  logic              err_no_addr;
`ifdef TRACE_DECODER_STATS_EN
  logic [15:0]       stat_reads;
  logic [15:0]       stat_writes;
  logic [15:0]       stat_ts;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit                m_held  = 1'b0;
  bit                m_write = 1'b0;
  logic [ADDR_W-1:0] m_eaddr = '0;
  logic [1:0]        m_ublb  = '0;
  logic [15:0]       m_data  = '0;
  logic [TIME_W-1:0] m_etime = '0;
  bit                m_err   = 1'b0;
  bit                m_av    = 1'b0;
  logic [ADDR_W-1:0] m_addr  = '0;
  logic [TIME_W-1:0] m_time  = '0;
`ifdef TRACE_DECODER_STATS_EN
  int m_sr = 0;
  int m_sw = 0;
  int m_st = 0;
`endif

  trace_decoder #(
    .ADDR_W (ADDR_W),
    .TIME_W (TIME_W)
  ) dut (
    .mclk        (mclk),
    .reset_n     (reset_n),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_type    (pkt_type),
    .pkt_payload (pkt_payload),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_write    (ev_write),
    .ev_addr     (ev_addr),
    .ev_ublb     (ev_ublb),
    .ev_data     (ev_data),
    .ev_time     (ev_time),
`ifdef TRACE_DECODER_STATS_EN
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes),
    .stat_ts     (stat_ts),
`endif
    .err_no_addr (err_no_addr)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [22:0] mk(input int ts, input int ublb, input int data);
    logic [4:0]  t;
    logic [1:0]  u;
    logic [15:0] d;
    t = 5'(ts);
    u = 2'(ublb);
    d = 16'(data);
    return {t, u, d};
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // One clock: drive inputs, check outputs at negedge, then advance the model.
  task automatic cycle(input bit pv, input logic [1:0] pt, input logic [22:0] pp,
                       input bit er, input bit rn);
    bit exp_ready;
    bit hs;
    bit produce;
    pkt_valid   = pv;
    pkt_type    = pt;
    pkt_payload = pp;
    ev_ready    = er;
    reset_n     = rn;
    @(negedge mclk);
    exp_ready = !m_held || er;
    chk("pkt_ready", 64'(pkt_ready), 64'(exp_ready));
    chk("ev_valid", 64'(ev_valid), 64'(m_held));
    chk("ev_write", 64'(ev_write), 64'(m_write));
    chk("ev_addr", 64'(ev_addr), 64'(m_eaddr));
    chk("ev_ublb", 64'(ev_ublb), 64'(m_ublb));
    chk("ev_data", 64'(ev_data), 64'(m_data));
    chk("ev_time", 64'(ev_time), 64'(m_etime));
    chk("err_no_addr", 64'(err_no_addr), 64'(m_err));
`ifdef TRACE_DECODER_STATS_EN
    chk("stat_reads", 64'(stat_reads), 64'(m_sr));
    chk("stat_writes", 64'(stat_writes), 64'(m_sw));
    chk("stat_ts", 64'(stat_ts), 64'(m_st));
`endif
    @(posedge mclk);
    if (!rn) begin
      m_held = 0; m_write = 0; m_eaddr = '0; m_ublb = '0; m_data = '0; m_etime = '0;
      m_err = 0; m_av = 0; m_addr = '0; m_time = '0;
`ifdef TRACE_DECODER_STATS_EN
      m_sr = 0; m_sw = 0; m_st = 0;
`endif
    end else begin
      hs = pv && exp_ready;
      produce = 0;
      if (hs) begin
        case (pt)
          PKT_ADDR: begin
            m_addr = pp;
            m_av   = 1;
          end
          PKT_TIME: begin
            m_time = m_time + 32'(pp);
`ifdef TRACE_DECODER_STATS_EN
            m_st = sat_inc(m_st);
`endif
          end
          default: begin
            m_time = m_time + 32'(pp[22:18]);
`ifdef TRACE_DECODER_STATS_EN
            if (pt == PKT_READ) m_sr = sat_inc(m_sr);
            else m_sw = sat_inc(m_sw);
`endif
            if (m_av) begin
              produce = 1;
              m_write = (pt == PKT_WRITE);
              m_eaddr = m_addr;
              m_ublb  = pp[17:16];
              m_data  = pp[15:0];
              m_etime = m_time;
              m_addr  = m_addr + 23'd1;
            end else begin
              m_err = 1;
            end
          end
        endcase
      end
      if (produce) m_held = 1;
      else if (er) m_held = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, PKT_ADDR, 23'd0, 1'b1, 1'b0);
  endtask

  initial begin
    pkt_valid   = 1'b0;
    pkt_type    = PKT_ADDR;
    pkt_payload = '0;
    ev_ready    = 1'b1;
    reset_n     = 1'b0;
    repeat (2) @(posedge mclk);
    #1;

    // Reset state
    cycle(1'b0, PKT_ADDR, 23'd0, 1'b1, 1'b1);

    // Basic read burst
    do_reset();
    cycle(1'b1, PKT_ADDR, 23'h000100, 1'b1, 1'b1);
    cycle(1'b1, PKT_READ, mk(3, 0, 16'hBEEF), 1'b1, 1'b1);
    chk("burst0_addr", 64'(ev_addr), 64'h100);
    chk("burst0_time", 64'(ev_time), 64'd3);
    chk("burst0_data", 64'(ev_data), 64'hBEEF);
    cycle(1'b1, PKT_READ, mk(1, 0, 16'h1234), 1'b1, 1'b1);
    chk("burst1_addr", 64'(ev_addr), 64'h101);
    chk("burst1_time", 64'(ev_time), 64'd4);
    cycle(1'b0, PKT_ADDR, 23'd0, 1'b1, 1'b1);

    // Large timestamp then write with ts5=31
    do_reset();
    cycle(1'b1, PKT_TIME, 23'h400000, 1'b1, 1'b1);
    cycle(1'b1, PKT_ADDR, 23'h4394F0, 1'b1, 1'b1);
    cycle(1'b1, PKT_WRITE, mk(31, 1, 16'h0078), 1'b1, 1'b1);
    chk("wr_write", 64'(ev_write), 64'd1);
    chk("wr_addr", 64'(ev_addr), 64'h4394F0);
    chk("wr_time", 64'(ev_time), 64'h40001F);
    chk("wr_ublb", 64'(ev_ublb), 64'd1);
    cycle(1'b0, PKT_ADDR, 23'd0, 1'b1, 1'b1);

    // Backpressure: ev_ready low 5 cycles with packets waiting
    do_reset();
    cycle(1'b1, PKT_ADDR, 23'h000200, 1'b1, 1'b1);
    cycle(1'b1, PKT_READ, mk(2, 3, 16'hA000), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, PKT_READ, mk(1, 2, 16'hA001), 1'b0, 1'b1);
      chk("stall_ready", 64'(pkt_ready), 64'd0);
      chk("stall_data", 64'(ev_data), 64'hA000);
    end
    cycle(1'b1, PKT_READ, mk(1, 2, 16'hA001), 1'b1, 1'b1);
    chk("release_addr", 64'(ev_addr), 64'h201);
    cycle(1'b1, PKT_WRITE, mk(0, 0, 16'hA002), 1'b1, 1'b1);
    chk("release_addr2", 64'(ev_addr), 64'h202);
    chk("same_time", 64'(ev_time), 64'd3);
    cycle(1'b0, PKT_ADDR, 23'd0, 1'b1, 1'b1);

    // Address wrap
    do_reset();
    cycle(1'b1, PKT_ADDR, 23'h7FFFFF, 1'b1, 1'b1);
    cycle(1'b1, PKT_READ, mk(1, 0, 16'h0001), 1'b1, 1'b1);
    chk("wrap_addr0", 64'(ev_addr), 64'h7FFFFF);
    cycle(1'b1, PKT_READ, mk(1, 0, 16'h0002), 1'b1, 1'b1);
    chk("wrap_addr1", 64'(ev_addr), 64'h000000);
    cycle(1'b0, PKT_ADDR, 23'd0, 1'b1, 1'b1);

    // Data with no address: dropped, error set, time still advances
    do_reset();
    cycle(1'b1, PKT_READ, mk(7, 0, 16'h5555), 1'b1, 1'b1);
    chk("noaddr_valid", 64'(ev_valid), 64'd0);
    chk("noaddr_err", 64'(err_no_addr), 64'd1);
    cycle(1'b1, PKT_ADDR, 23'h000010, 1'b1, 1'b1);
    cycle(1'b1, PKT_READ, mk(0, 0, 16'h6666), 1'b1, 1'b1);
    chk("noaddr_time", 64'(ev_time), 64'd7);
    do_reset();
    chk("err_cleared", 64'(err_no_addr), 64'd0);

    // Reset mid-burst discards held event; next data packet flags error
    cycle(1'b1, PKT_ADDR, 23'h000300, 1'b1, 1'b1);
    cycle(1'b1, PKT_READ, mk(1, 0, 16'h7777), 1'b0, 1'b1);
    cycle(1'b1, PKT_READ, mk(1, 0, 16'h8888), 1'b0, 1'b0);
    chk("midburst_valid", 64'(ev_valid), 64'd0);
    cycle(1'b1, PKT_WRITE, mk(1, 0, 16'h9999), 1'b1, 1'b1);
    chk("midburst_err", 64'(err_no_addr), 64'd1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [1:0]  t;
      logic [22:0] p;
      bit          v;
      bit          r;
      bit          rn;
      t  = 2'($urandom_range(0, 3));
      p  = 23'($urandom);
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 3) != 0);
      rn = ($urandom_range(0, 199) != 0);
      if (t == PKT_ADDR && $urandom_range(0, 3) == 0) p = 23'h7FFFFE;
      cycle(v, t, p, r, rn);
    end

`ifdef TRACE_DECODER_STATS_EN
    do_reset();
    cycle(1'b1, PKT_ADDR, 23'h000000, 1'b1, 1'b1);
    for (int i = 0; i < 70000; i++) begin
      cycle(1'b1, PKT_READ, mk(0, 0, i), 1'b1, 1'b1);
    end
    cycle(1'b0, PKT_ADDR, 23'd0, 1'b1, 1'b1);
    chk("stat_reads_sat", 64'(stat_reads), 64'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
